// File: rtl/or1200_fwd_sched.sv
// Operand forwarding and load-use hazard scheduler for the ID-stage operand muxes.
// Optional statistics counters are enabled by defining OR1200_FWD_STATS_EN.
module or1200_fwd_sched #(
  parameter int AW        = 5,
  parameter int SELW      = 2,
  parameter int STALL_MAX = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_freeze,
  input  logic            ex_freeze,
  input  logic [AW-1:0]   id_rfa_addr,
  input  logic            id_rfa_en,
  input  logic [AW-1:0]   id_rfb_addr,
  input  logic            id_rfb_en,
  input  logic            id_imm_sel,
  input  logic [AW-1:0]   id_rfwb_addr,
  input  logic            id_rfwb_en,
  input  logic            id_is_load,
  input  logic            lsu_done,
  output logic [SELW-1:0] sel_a,
  output logic [SELW-1:0] sel_b,
  output logic            hazard_stall,
  output logic            stall_err,
  output logic [AW-1:0]   ex_rfwb_addr,
  output logic [AW-1:0]   wb_rfwb_addr
`ifdef OR1200_FWD_STATS_EN
  ,
  output logic [15:0]     stat_stall_cyc,
  output logic [15:0]     stat_fwd_cnt
`endif
);

  localparam logic [SELW-1:0] SEL_RF  = SELW'(0);
  localparam logic [SELW-1:0] SEL_IMM = SELW'(1);
  localparam logic [SELW-1:0] SEL_EX  = SELW'(2);
  localparam logic [SELW-1:0] SEL_WB  = SELW'(3);
  localparam logic [7:0]      STALL_LIM = 8'(STALL_MAX);

  typedef enum logic {ST_IDLE, ST_LDWAIT} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ex_addr_q, ex_addr_d, wb_addr_q, wb_addr_d;
  logic          ex_en_q, ex_en_d, ex_ld_q, ex_ld_d;
  logic          wb_en_q, wb_en_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          a_ex, a_wb, b_ex, b_wb, load_hazard;

  // r0 is hardwired to zero, so it never takes a forwarded value.
  function automatic logic match(input logic src_en, input logic [AW-1:0] src_addr,
                                 input logic st_en, input logic [AW-1:0] st_addr);
    return src_en && st_en && (src_addr == st_addr) && (src_addr != '0);
  endfunction

  assign a_ex = match(id_rfa_en, id_rfa_addr, ex_en_q, ex_addr_q);
  assign a_wb = match(id_rfa_en, id_rfa_addr, wb_en_q, wb_addr_q);
  assign b_ex = match(id_rfb_en, id_rfb_addr, ex_en_q, ex_addr_q);
  assign b_wb = match(id_rfb_en, id_rfb_addr, wb_en_q, wb_addr_q);

  assign load_hazard  = ex_ld_q && (a_ex || (b_ex && !id_imm_sel));
  assign hazard_stall = load_hazard && !lsu_done;
  assign stall_err    = err_q;
  assign ex_rfwb_addr = ex_addr_q;
  assign wb_rfwb_addr = wb_addr_q;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    sel_a = SEL_RF;
    sel_b = SEL_RF;
    if (a_ex)      sel_a = SEL_EX;
    else if (a_wb) sel_a = SEL_WB;
    if (id_imm_sel) sel_b = SEL_IMM;
    else if (b_ex)  sel_b = SEL_EX;
    else if (b_wb)  sel_b = SEL_WB;
  end

  always_comb begin
    ex_addr_d = ex_addr_q;
    ex_en_d   = ex_en_q;
    ex_ld_d   = ex_ld_q;
    wb_addr_d = wb_addr_q;
    wb_en_d   = wb_en_q;
    if (!id_freeze) begin
      ex_addr_d = id_rfwb_addr;
      ex_en_d   = id_rfwb_en;
      ex_ld_d   = id_is_load;
    end else if (!ex_freeze) begin
      // Bubble: the address is left alone, only the valid bits drop.
      ex_en_d = 1'b0;
      ex_ld_d = 1'b0;
    end
    if (!ex_freeze) begin
      wb_addr_d = ex_addr_q;
      wb_en_d   = ex_en_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (hazard_stall) state_d = ST_LDWAIT;
      end
      ST_LDWAIT: begin
        if (lsu_done || !load_hazard) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != STALL_LIM) begin
          cnt_d = cnt_q + 8'd1;
          err_d = (cnt_q + 8'd1 == STALL_LIM);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ex_addr_q <= '0;
      ex_en_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_en_q   <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ex_addr_q <= ex_addr_d;
      ex_en_q   <= ex_en_d;
      ex_ld_q   <= ex_ld_d;
      wb_addr_q <= wb_addr_d;
      wb_en_q   <= wb_en_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

`ifdef OR1200_FWD_STATS_EN
  logic [15:0] stall_cyc_q, fwd_cnt_q;
  logic        fwd_now;

  assign fwd_now = !id_freeze && ((sel_a == SEL_EX) || (sel_a == SEL_WB) ||
                                  (sel_b == SEL_EX) || (sel_b == SEL_WB));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (hazard_stall && stall_cyc_q != 16'hFFFF) stall_cyc_q <= stall_cyc_q + 16'd1;
      if (fwd_now && fwd_cnt_q != 16'hFFFF)        fwd_cnt_q   <= fwd_cnt_q + 16'd1;
    end
  end

  assign stat_stall_cyc = stall_cyc_q;
  assign stat_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_or1200_fwd_sched.sv
// Directed scoreboard bench for or1200_fwd_sched: stimulus pushes expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_or1200_fwd_sched;

  logic       clk, rst;
  logic       id_freeze, ex_freeze;
  logic [4:0] id_rfa_addr, id_rfb_addr, id_rfwb_addr;
  logic       id_rfa_en, id_rfb_en, id_imm_sel, id_rfwb_en, id_is_load, lsu_done;
  logic [1:0] sel_a, sel_b;
  logic       hazard_stall, stall_err;
  logic [4:0] ex_rfwb_addr, wb_rfwb_addr;
`ifdef OR1200_FWD_STATS_EN
  logic [15:0] stat_stall_cyc, stat_fwd_cnt;
`endif

  or1200_fwd_sched dut (
    .clk(clk), .rst(rst),
    .id_freeze(id_freeze), .ex_freeze(ex_freeze),
    .id_rfa_addr(id_rfa_addr), .id_rfa_en(id_rfa_en),
    .id_rfb_addr(id_rfb_addr), .id_rfb_en(id_rfb_en),
    .id_imm_sel(id_imm_sel),
    .id_rfwb_addr(id_rfwb_addr), .id_rfwb_en(id_rfwb_en),
    .id_is_load(id_is_load), .lsu_done(lsu_done),
    .sel_a(sel_a), .sel_b(sel_b),
    .hazard_stall(hazard_stall), .stall_err(stall_err),
    .ex_rfwb_addr(ex_rfwb_addr), .wb_rfwb_addr(wb_rfwb_addr)
`ifdef OR1200_FWD_STATS_EN
    , .stat_stall_cyc(stat_stall_cyc), .stat_fwd_cnt(stat_fwd_cnt)
`endif
  );

  typedef struct {
    string      name;
    logic [1:0] sa, sb;
    logic       st, er;
    logic [4:0] exa, wba;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic chk;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (chk) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard: DUT output sampled with no expectation queued");
      end else begin
        cur = exp_q.pop_front();
        if (sel_a !== cur.sa || sel_b !== cur.sb || hazard_stall !== cur.st ||
            stall_err !== cur.er || ex_rfwb_addr !== cur.exa || wb_rfwb_addr !== cur.wba) begin
          bad++;
          $display("FAIL %s: got sa=%0d sb=%0d stall=%0d err=%0d ex=%0d wb=%0d, want sa=%0d sb=%0d stall=%0d err=%0d ex=%0d wb=%0d",
                   cur.name, sel_a, sel_b, hazard_stall, stall_err, ex_rfwb_addr, wb_rfwb_addr,
                   cur.sa, cur.sb, cur.st, cur.er, cur.exa, cur.wba);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] a, input logic ae, input logic [4:0] b, input logic be,
                        input logic imm, input logic [4:0] w, input logic we, input logic ld);
    id_rfa_addr  = a;  id_rfa_en  = ae;
    id_rfb_addr  = b;  id_rfb_en  = be;
    id_imm_sel   = imm;
    id_rfwb_addr = w;  id_rfwb_en = we;
    id_is_load   = ld;
  endtask

  task automatic set_ctl(input logic idf, input logic exf, input logic done);
    id_freeze = idf;
    ex_freeze = exf;
    lsu_done  = done;
  endtask

  // Queue the expected outputs for the current cycle, then advance one clock.
  task automatic cyc(input string name, input logic [1:0] sa, input logic [1:0] sb,
                     input logic st, input logic er, input logic [4:0] exa, input logic [4:0] wba);
    exp_t e;
    e.name = name; e.sa = sa; e.sb = sb; e.st = st; e.er = er; e.exa = exa; e.wba = wba;
    exp_q.push_back(e);
    chk = 1'b1;
    tick();
  endtask

  initial begin
    chk = 1'b0;
    rst = 1'b1;
    set_ctl(0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    cyc("reset", 2'd0, 2'd0, 0, 0, 5'd0, 5'd0);
    rst = 1'b0;

    // EX forwarding and WB forwarding / EX priority
    set_id(0, 0, 0, 0, 0, 5'd3, 1, 0);
    cyc("issue_r3", 2'd0, 2'd0, 0, 0, 5'd0, 5'd0);
    set_id(5'd3, 1, 5'd4, 1, 0, 5'd5, 1, 0);
    cyc("ex_fwd_a", 2'd2, 2'd0, 0, 0, 5'd3, 5'd0);
    set_id(0, 0, 0, 0, 0, 5'd6, 1, 0);
    cyc("issue_r6", 2'd0, 2'd0, 0, 0, 5'd5, 5'd3);
    set_id(5'd3, 1, 5'd5, 1, 0, 5'd5, 1, 0);
    cyc("wb_fwd_b", 2'd0, 2'd3, 0, 0, 5'd6, 5'd5);
    set_id(0, 0, 5'd6, 1, 0, 5'd5, 1, 0);
    cyc("wb_fwd_b2", 2'd0, 2'd3, 0, 0, 5'd5, 5'd6);
    set_id(5'd5, 1, 5'd5, 1, 0, 5'd0, 1, 0);
    cyc("ex_over_wb", 2'd2, 2'd2, 0, 0, 5'd5, 5'd5);
    set_id(5'd0, 1, 5'd5, 1, 1, 5'd0, 0, 0);
    cyc("r0_and_imm", 2'd0, 2'd1, 0, 0, 5'd0, 5'd5);

    // Load-use stall for three cycles, then data arrives
    set_id(0, 0, 0, 0, 0, 5'd7, 1, 1);
    cyc("issue_load", 2'd0, 2'd0, 0, 0, 5'd0, 5'd0);
    set_id(5'd7, 1, 5'd2, 1, 0, 5'd8, 1, 0);
    set_ctl(1, 1, 0);
    for (int i = 0; i < 3; i++) cyc("load_stall", 2'd2, 2'd0, 1, 0, 5'd7, 5'd0);
    set_ctl(0, 0, 1);
    cyc("load_done", 2'd2, 2'd0, 0, 0, 5'd7, 5'd0);
    set_ctl(0, 0, 0);
    set_id(5'd8, 1, 0, 0, 0, 5'd0, 0, 0);
    cyc("after_load", 2'd2, 2'd0, 0, 0, 5'd8, 5'd7);

    // Freeze handling: bubble then full hold
    set_id(0, 0, 0, 0, 0, 5'd9, 1, 0);
    cyc("issue_r9", 2'd0, 2'd0, 0, 0, 5'd0, 5'd8);
    set_ctl(1, 0, 0);
    set_id(5'd9, 1, 0, 0, 0, 5'd10, 1, 0);
    cyc("id_freeze", 2'd2, 2'd0, 0, 0, 5'd9, 5'd0);
    set_ctl(0, 0, 0);
    cyc("bubble", 2'd3, 2'd0, 0, 0, 5'd9, 5'd9);
    set_ctl(1, 1, 0);
    set_id(5'd10, 1, 5'd9, 1, 0, 5'd11, 1, 0);
    cyc("both_freeze", 2'd2, 2'd0, 0, 0, 5'd10, 5'd9);
    cyc("both_hold", 2'd2, 2'd0, 0, 0, 5'd10, 5'd9);

    // Watchdog: long stall, single stall_err pulse, then reset mid-wait
    set_ctl(0, 0, 0);
    set_id(0, 0, 0, 0, 0, 5'd12, 1, 1);
    cyc("issue_load2", 2'd0, 2'd0, 0, 0, 5'd10, 5'd9);
    set_ctl(1, 1, 0);
    set_id(5'd12, 1, 5'd12, 1, 0, 5'd13, 1, 0);
    for (int k = 0; k < 260; k++)
      cyc((k == 256) ? "stall_err_pulse" : "long_stall", 2'd2, 2'd2, 1, (k == 256), 5'd12, 5'd10);
    rst = 1'b1;
    cyc("rst_cycle", 2'd2, 2'd2, 1, 0, 5'd12, 5'd10);
    rst = 1'b0;
    set_ctl(0, 0, 0);
    cyc("post_reset", 2'd0, 2'd0, 0, 0, 5'd0, 5'd0);
    cyc("post_reset2", 2'd0, 2'd0, 0, 0, 5'd13, 5'd0);

    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/or1200_fwd_sched.md
Name: or1200_fwd_sched

Overview:
- Forwarding and hazard scheduler for the register-file operand muxes.
- Tracks destination registers of the EX and WB pipeline stages.
- Compares them against ID-stage source addresses and drives the operand-mux select codes sel_a/sel_b.
- Detects load-use hazards, requests an ID stall until load data is available, and flags stalls that run too long.

Parameters:
- AW, 5, register address width.
- SELW, 2, select code width. Codes: RF=2'd0, IMM=2'd1, EX_FORW=2'd2, WB_FORW=2'd3.
- STALL_MAX, 255, load-stall cycle limit before stall_err fires (8-bit counter).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_freeze  in  1  ID stage frozen
- ex_freeze  in  1  EX stage frozen
- id_rfa_addr  in  AW  ID source A address
- id_rfa_en  in  1  source A read valid
- id_rfb_addr  in  AW  ID source B address
- id_rfb_en  in  1  source B read valid
- id_imm_sel  in  1  operand B takes immediate
- id_rfwb_addr  in  AW  ID destination address
- id_rfwb_en  in  1  ID instruction writes RF
- id_is_load  in  1  ID instruction is a load
- lsu_done  in  1  load in EX has data on ex_forw this cycle
- sel_a  out  SELW  operand A select
- sel_b  out  SELW  operand B select
- hazard_stall  out  1  load-use stall request to freeze logic
- stall_err  out  1  one-cycle pulse, stall exceeded STALL_MAX
- ex_rfwb_addr  out  AW  EX-stage destination (registered)
- wb_rfwb_addr  out  AW  WB-stage destination (registered)

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset: all stage registers (addr, en, is_load) = 0; FSM = IDLE; stall counter = 0; stall_err = 0. sel_a/sel_b = RF, hazard_stall = 0 (derived from zeroed state).
- EX stage registers:
  - !id_freeze: capture the id_rfwb_* / id_is_load fields.
  - id_freeze && !ex_freeze: load a bubble (en=0, is_load=0; addr holds).
  - ex_freeze: hold.
- WB stage registers: capture the EX fields when !ex_freeze; otherwise hold.
- Match rule: srcX matches stage S iff srcX_en && S.en && S.addr == srcX addr && addr != 0. r0 never forwards.
- sel_a (combinational from ID inputs and stage registers):
  - EX match → EX_FORW.
  - else WB match → WB_FORW.
  - else RF.
- sel_b: id_imm_sel → IMM, overriding everything; otherwise the same rule as sel_a.
- load_hazard = EX.is_load && (A matches EX || B matches EX, B only when !id_imm_sel).
- FSM:
  - IDLE: load_hazard && !lsu_done → LDWAIT.
  - LDWAIT: lsu_done → IDLE; load_hazard falls (EX flushed) → IDLE.
- hazard_stall = load_hazard && !lsu_done, in IDLE or LDWAIT. No stall if lsu_done coincides with detection. Zero-cycle latency: combinational on the current state.
- Stall counter:
  - Increments each LDWAIT cycle; clears on exit or reset.
  - On reaching STALL_MAX, stall_err pulses once and the counter saturates.
  - The FSM stays in LDWAIT; no forced exit.
- Hazard with both freezes asserted: the hazard is still reported. Stage registers hold.
- Reset mid-LDWAIT: next cycle IDLE, stall deasserted, no stall_err.
- Simultaneous EX and WB match on the same address: EX wins (youngest value).

Optional Feature:
- Macro OR1200_FWD_STATS_EN.
- When defined, adds outputs stat_stall_cyc[15:0] and stat_fwd_cnt[15:0]:
  - stat_stall_cyc counts cycles with hazard_stall=1.
  - stat_fwd_cnt counts cycles with !id_freeze and sel_a or sel_b in {EX_FORW, WB_FORW}.
  - Both saturate at 16'hFFFF and clear on rst.
- When not defined: the ports are absent, there is no counter logic, and all other behaviour is identical.

Test Plan:
- EX-stage forward: issue a write to r3 (en=1, !is_load), then next instr with A=r3, B=r4, freezes low → sel_a=2'd2, sel_b=2'd0, hazard_stall=0.
- WB forward and EX priority:
  - r5 written two instrs back, B=r5 → sel_b=2'd3.
  - Both EX and WB write r5 → sel_b=2'd2.
  - id_imm_sel=1 → sel_b=2'd1.
- r0 exclusion: EX writes r0 (en=1), A=r0 → sel_a=2'd0.
- Load-use stall:
  - Load to r7 in EX, A=r7, lsu_done low 3 cycles → hazard_stall=1 for 3 cycles.
  - Cycle with lsu_done=1 → hazard_stall=0, sel_a=2'd2, FSM returns to IDLE.
- Watchdog and reset: hold a load hazard with lsu_done=0 → stall_err is a single pulse on the cycle the counter reaches 255. Then assert rst one cycle → next cycle hazard_stall=0, all stage addresses 0, sel_a=sel_b=2'd0.
- Freeze handling: id_freeze=1, ex_freeze=0 for one cycle → EX en becomes 0 (bubble), WB captures the prior EX. With both freezes high, all stage registers hold.
